// File: rtl/dds_sweep_ctrl.sv
// Linear chirp generator feeding the DDS tuning word: single up-sweep or continuous triangle.
// Latency: start -> f_start one edge later; no backpressure, every output is registered.
module dds_sweep_ctrl #(
  parameter int TUNE_WIDTH  = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   n_RST,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode,
  input  logic [TUNE_WIDTH-1:0]  f_start,
  input  logic [TUNE_WIDTH-1:0]  f_stop,
  input  logic [TUNE_WIDTH-1:0]  f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [TUNE_WIDTH-1:0]  tuning_word,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   cfg_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  logic [1:0]             state;
  logic                   cfg_mode;
  logic [TUNE_WIDTH-1:0]  cfg_start;
  logic [TUNE_WIDTH-1:0]  cfg_stop;
  logic [TUNE_WIDTH-1:0]  cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [DWELL_WIDTH-1:0] dwell_cnt;

  logic [TUNE_WIDTH:0]    up_sum;
  logic [TUNE_WIDTH:0]    down_lim;
  logic [TUNE_WIDTH-1:0]  up_word;
  logic [TUNE_WIDTH-1:0]  down_word;
  logic [DWELL_WIDTH-1:0] cfg_reload;
  logic [DWELL_WIDTH-1:0] start_reload;
  logic                   start_ok;
  logic                   dwell_last;

  // Extra top bit keeps carry/borrow visible so the clamps catch overflow instead of wrapping.
  always_comb begin
    up_sum       = {1'b0, tuning_word} + {1'b0, cfg_step};
    up_word      = (up_sum >= {1'b0, cfg_stop}) ? cfg_stop : up_sum[TUNE_WIDTH-1:0];
    down_lim     = {1'b0, cfg_start} + {1'b0, cfg_step};
    down_word    = ({1'b0, tuning_word} <= down_lim) ? cfg_start : (tuning_word - cfg_step);
    cfg_reload   = (cfg_dwell == '0) ? '0 : (cfg_dwell - DWELL_ONE);
    start_reload = (dwell == '0) ? '0 : (dwell - DWELL_ONE);
    start_ok     = (f_step != '0) && (f_stop > f_start);
    dwell_last   = (dwell_cnt == '0);
  end

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      state       <= IDLE;
      tuning_word <= '0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      cfg_err     <= 1'b0;
      dwell_cnt   <= '0;
      cfg_mode    <= 1'b0;
      cfg_start   <= '0;
      cfg_stop    <= '0;
      cfg_step    <= '0;
      cfg_dwell   <= '0;
    end else begin
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (start_ok) begin
                cfg_mode    <= mode;
                cfg_start   <= f_start;
                cfg_stop    <= f_stop;
                cfg_step    <= f_step;
                cfg_dwell   <= dwell;
                tuning_word <= f_start;
                dwell_cnt   <= start_reload;
                busy        <= 1'b1;
                state       <= UP;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          UP: begin
            if (!dwell_last) begin
              dwell_cnt <= dwell_cnt - DWELL_ONE;
            end else if (tuning_word == cfg_stop) begin
              if (cfg_mode) begin
                state       <= DOWN;
                tuning_word <= down_word;
                dwell_cnt   <= cfg_reload;
              end else begin
                state      <= IDLE;
                busy       <= 1'b0;
                sweep_done <= 1'b1;
              end
            end else begin
              tuning_word <= up_word;
              dwell_cnt   <= cfg_reload;
            end
          end
          DOWN: begin
            if (!dwell_last) begin
              dwell_cnt <= dwell_cnt - DWELL_ONE;
            end else if (tuning_word == cfg_start) begin
              // Bottom of the triangle closes one period.
              state       <= UP;
              tuning_word <= up_word;
              dwell_cnt   <= cfg_reload;
              sweep_done  <= 1'b1;
            end else begin
              tuning_word <= down_word;
              dwell_cnt   <= cfg_reload;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: single sweeps, clamping, overflow, triangle, errors, reset.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        n_RST;
  logic        start;
  logic        abort;
  logic        mode;
  logic [15:0] f_start;
  logic [15:0] f_stop;
  logic [15:0] f_step;
  logic [15:0] dwell;
  logic [15:0] tuning_word;
  logic        busy;
  logic        sweep_done;
  logic        cfg_err;

  int n_vec;
  int n_err;

  dds_sweep_ctrl #(.TUNE_WIDTH(16), .DWELL_WIDTH(16)) dut (
    .clk         (clk),
    .n_RST       (n_RST),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .tuning_word (tuning_word),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .cfg_err     (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [15:0] fs, input logic [15:0] fe,
                          input logic [15:0] fp, input logic [15:0] dw);
    mode    = m;
    f_start = fs;
    f_stop  = fe;
    f_step  = fp;
    dwell   = dw;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Checks an up-sweep of n words each held 'hold' cycles, starting at edge 1 after do_start.
  // With poke set, a conflicting start is thrown at the busy block on edge 3.
  task automatic check_single(input string tag, input int n, input int hold, input bit poke,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int e = 1; e <= n * hold; e++) begin
      chk({tag, "_tw"}, 32'(tuning_word), 32'(w[(e - 1) / hold]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(sweep_done), 32'd0);
      chk({tag, "_err"}, 32'(cfg_err), 32'd0);
      if (poke && e == 3) begin
        f_start = 16'd500;
        f_stop  = 16'd900;
        f_step  = 16'd1;
        dwell   = 16'd1;
        start   = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk({tag, "_end_done"}, 32'(sweep_done), 32'd1);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_tw"}, 32'(tuning_word), 32'(w[n - 1]));
    tick();
    chk({tag, "_post_done"}, 32'(sweep_done), 32'd0);
    chk({tag, "_post_tw"}, 32'(tuning_word), 32'(w[n - 1]));
  endtask

  logic [15:0] tri_tab [22];

  initial begin
    n_vec   = 0;
    n_err   = 0;
    n_RST   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    mode    = 1'b0;
    f_start = 16'd0;
    f_stop  = 16'd0;
    f_step  = 16'd0;
    dwell   = 16'd0;
    tri_tab = '{16'd0, 16'd0, 16'd10, 16'd10, 16'd20, 16'd20, 16'd30, 16'd30,
                16'd20, 16'd20, 16'd10, 16'd10, 16'd0, 16'd0, 16'd10, 16'd10,
                16'd20, 16'd20, 16'd30, 16'd30, 16'd20, 16'd20};

    #12;
    chk("rst_tw", 32'(tuning_word), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    n_RST = 1'b1;
    tick();

    // Single sweep; inputs scrambled after start must not matter.
    do_start(1'b0, 16'd100, 16'd130, 16'd10, 16'd4);
    f_start = 16'd7;
    f_stop  = 16'd9;
    f_step  = 16'd0;
    dwell   = 16'd0;
    mode    = 1'b1;
    check_single("single", 4, 4, 1'b0, 16'd100, 16'd110, 16'd120, 16'd130);

    do_start(1'b0, 16'd100, 16'd125, 16'd10, 16'd4);
    check_single("clamp", 4, 4, 1'b0, 16'd100, 16'd110, 16'd120, 16'd125);

    do_start(1'b0, 16'hFFF0, 16'hFFFF, 16'h0020, 16'd1);
    check_single("ovf", 2, 1, 1'b0, 16'hFFF0, 16'hFFFF, 16'h0000, 16'h0000);

    // Triangle, aborted while descending.
    do_start(1'b1, 16'd0, 16'd30, 16'd10, 16'd2);
    for (int e = 1; e <= 22; e++) begin
      chk("tri_tw", 32'(tuning_word), 32'(tri_tab[e - 1]));
      chk("tri_busy", 32'(busy), 32'd1);
      chk("tri_done", 32'(sweep_done), (e == 15) ? 32'd1 : 32'd0);
      tick();
      if (e == 21) abort = 1'b1;
    end
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tw", 32'(tuning_word), 32'd20);
    chk("abort_done", 32'(sweep_done), 32'd0);
    abort = 1'b0;
    tick();
    chk("abort_idle_tw", 32'(tuning_word), 32'd20);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // Rejected configurations.
    do_start(1'b0, 16'd100, 16'd130, 16'd0, 16'd4);
    chk("err_step_pulse", 32'(cfg_err), 32'd1);
    chk("err_step_busy", 32'(busy), 32'd0);
    tick();
    chk("err_step_clear", 32'(cfg_err), 32'd0);
    chk("err_step_idle", 32'(busy), 32'd0);
    do_start(1'b0, 16'd100, 16'd100, 16'd10, 16'd4);
    chk("err_eq_pulse", 32'(cfg_err), 32'd1);
    chk("err_eq_busy", 32'(busy), 32'd0);
    chk("err_eq_tw", 32'(tuning_word), 32'd20);
    tick();
    chk("err_eq_clear", 32'(cfg_err), 32'd0);

    do_start(1'b0, 16'd100, 16'd130, 16'd10, 16'd0);
    check_single("dwell0", 4, 1, 1'b0, 16'd100, 16'd110, 16'd120, 16'd130);

    // Asynchronous reset mid-sweep, observed between clock edges.
    do_start(1'b0, 16'd100, 16'd130, 16'd10, 16'd4);
    for (int e = 1; e < 5; e++) tick();
    chk("pre_rst_tw", 32'(tuning_word), 32'd110);
    #1;
    n_RST = 1'b0;
    #1;
    chk("async_rst_tw", 32'(tuning_word), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    #1;
    n_RST = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(sweep_done), 32'd0);
    chk("post_rst_tw", 32'(tuning_word), 32'd0);

    // start and abort together in IDLE.
    mode    = 1'b0;
    f_start = 16'd100;
    f_stop  = 16'd130;
    f_step  = 16'd10;
    dwell   = 16'd4;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start   = 1'b0;
    abort   = 1'b0;
    chk("coll_busy", 32'(busy), 32'd0);
    chk("coll_tw", 32'(tuning_word), 32'd0);
    chk("coll_err", 32'(cfg_err), 32'd0);
    tick();
    chk("coll_busy2", 32'(busy), 32'd0);

    do_start(1'b0, 16'd100, 16'd130, 16'd10, 16'd4);
    check_single("busy_start", 4, 4, 1'b1, 16'd100, 16'd110, 16'd120, 16'd130);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
